// File: rtl/pingpong_block_buffer.sv
// pingpong_block_buffer: double-buffered block store.
// While one bank of BLOCK_SIZE words is filled from the input stream, the other
// bank, once it is complete, is drained to the consumer through a one-deep
// registered output stage.
//
// Ports:
//   i_clk            clock, all logic on rising edge
//   i_rst            synchronous reset, active-high
//   i_start_block    restart fill of current write bank (drops partial data)
//   i_in_valid       input sample valid
//   i_in_data        input sample
//   o_in_ready       input accepted when i_in_valid && o_in_ready (combinational)
//   o_out_valid      output sample valid
//   o_out_data       output sample (registered)
//   o_out_last       final word of a drained block
//   i_out_ready      consumer accepts when o_out_valid && i_out_ready
//   o_block_done     one-cycle pulse the cycle after a block's final write
//   o_blocks_ready   number of full banks not yet fully read (0..2)
module pingpong_block_buffer #(
  parameter int unsigned BLOCK_SIZE = 256,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start_block,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_last,
  input  logic              i_out_ready,
  output logic              o_block_done,
  output logic [1:0]        o_blocks_ready
);

  localparam int unsigned PTR_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int unsigned DEPTH = 2 * BLOCK_SIZE;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BLOCK_SIZE - 1);

  // Both banks in one array; the bank select is the address MSB.
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  logic              r_wb;
  logic              r_rb;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [1:0]        r_bank_full;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic              r_block_done;
  logic [1:0]        r_blocks_ready;

  logic              w_in_ready;
  logic              w_wr_acc;
  logic              w_wr_end;
  logic              w_rd_load;
  logic              w_rd_end;
  logic [1:0]        w_bank_full_nxt;
  logic [PTR_W:0]    w_wr_addr;
  logic [PTR_W:0]    w_rd_addr;

  // Handshake and bank-transition qualifiers.
  assign w_in_ready = !i_rst && !r_bank_full[r_wb] && !i_start_block;
  assign w_wr_acc   = i_in_valid && w_in_ready;
  assign w_wr_end   = w_wr_acc && (r_wr_ptr == LAST_PTR);
  assign w_rd_load  = r_bank_full[r_rb] && (!r_out_valid || i_out_ready);
  assign w_rd_end   = w_rd_load && (r_rd_ptr == LAST_PTR);
  assign w_wr_addr  = {r_wb, r_wr_ptr};
  assign w_rd_addr  = {r_rb, r_rd_ptr};

  // Writer and reader always address different banks, so both updates can land.
  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (w_wr_end) w_bank_full_nxt[r_wb] = 1'b1;
    if (w_rd_end) w_bank_full_nxt[r_rb] = 1'b0;
  end

  // Sample storage; contents are don't-care after reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) r_mem[w_wr_addr] <= i_in_data;
  end

  // Pointer, bank and output-stage registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wb           <= 1'b0;
      r_rb           <= 1'b0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_bank_full    <= '0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_last     <= 1'b0;
      r_block_done   <= 1'b0;
      r_blocks_ready <= '0;
    end else begin
      r_block_done   <= w_wr_end;
      r_bank_full    <= w_bank_full_nxt;
      r_blocks_ready <= 2'(w_bank_full_nxt[0]) + 2'(w_bank_full_nxt[1]);

      // start_block only rewinds the fill pointer of the current bank.
      if (i_start_block) begin
        r_wr_ptr <= '0;
      end else if (w_wr_acc) begin
        if (w_wr_end) begin
          r_wr_ptr <= '0;
          r_wb     <= ~r_wb;
        end else begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
      end

      if (w_rd_load) begin
        r_out_data  <= r_mem[w_rd_addr];
        r_out_valid <= 1'b1;
        r_out_last  <= (r_rd_ptr == LAST_PTR);
        if (w_rd_end) begin
          r_rd_ptr <= '0;
          r_rb     <= ~r_rb;
        end else begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
      end else if (i_out_ready) begin
        // Data is left in place; only the qualifiers drop.
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign o_in_ready     = w_in_ready;
  assign o_out_valid    = r_out_valid;
  assign o_out_data     = r_out_data;
  assign o_out_last     = r_out_last;
  assign o_block_done   = r_block_done;
  assign o_blocks_ready = r_blocks_ready;

endmodule

// File: tb/tb_pingpong_block_buffer.sv
// Directed testbench for pingpong_block_buffer with BLOCK_SIZE=4, DATA_W=16.
// Inputs change 1 time unit after a rising edge; outputs are checked 2 units
// after the edge, well away from the active edge.
module tb_pingpong_block_buffer;

  localparam int unsigned BS = 4;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_block;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          block_done;
  logic [1:0]    blocks_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pingpong_block_buffer #(.BLOCK_SIZE(BS), .DATA_W(DW)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start_block  (start_block),
    .i_in_valid     (in_valid),
    .i_in_data      (in_data),
    .o_in_ready     (in_ready),
    .o_out_valid    (out_valid),
    .o_out_data     (out_data),
    .o_out_last     (out_last),
    .i_out_ready    (out_ready),
    .o_block_done   (block_done),
    .o_blocks_ready (blocks_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_block = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_last !== 1'b0 ||
        block_done !== 1'b0 || blocks_ready !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got v=%b d=%h l=%b bd=%b br=%0d exp 0,0000,0,0,0",
               out_valid, out_data, out_last, block_done, blocks_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_d;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      in_valid = (c < 4);
      in_data  = DW'(32'h10 + c);
      #1;
      checks++;
      if (block_done !== (c == 4)) begin failures++; $display("FAIL basic_block_done c=%0d got=%b exp=%b", c, block_done, (c == 4)); end
      checks++;
      if (out_valid !== (c >= 5 && c <= 8)) begin failures++; $display("FAIL basic_out_valid c=%0d got=%b exp=%b", c, out_valid, (c >= 5 && c <= 8)); end
      checks++;
      if (out_last !== (c == 8)) begin failures++; $display("FAIL basic_out_last c=%0d got=%b exp=%b", c, out_last, (c == 8)); end
      if (c >= 5 && c <= 8) begin
        exp_d = DW'(32'h10 + c - 5);
        checks++;
        if (out_data !== exp_d) begin failures++; $display("FAIL basic_out_data c=%0d got=%h exp=%h", c, out_data, exp_d); end
      end
      if (c < 4) begin
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready c=%0d got=%b exp=1", c, in_ready); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_d;
    do_reset();
    out_ready = 1'b0;
    // Eight words fill both banks; the ninth (0x08) is held off.
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1;
      in_data  = (c < 8) ? DW'(c) : 16'h0008;
      #1;
      checks++;
      if (in_ready !== (c < 8)) begin failures++; $display("FAIL bp_fill_in_ready c=%0d got=%b exp=%b", c, in_ready, (c < 8)); end
      step();
    end
    checks++;
    if (blocks_ready !== 2'd2) begin failures++; $display("FAIL bp_blocks_ready_full got=%0d exp=2", blocks_ready); end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0000) begin
      failures++; $display("FAIL bp_first_word_held got v=%b d=%h exp v=1 d=0000", out_valid, out_data);
    end
    // Drain bank 0; in_ready returns while 0x03 is on the output.
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_d = DW'(k);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d) begin failures++; $display("FAIL bp_drain_data k=%0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, exp_d); end
      checks++;
      if (out_last !== (k == 3)) begin failures++; $display("FAIL bp_drain_last k=%0d got=%b exp=%b", k, out_last, (k == 3)); end
      checks++;
      if (in_ready !== (k == 3)) begin failures++; $display("FAIL bp_drain_in_ready k=%0d got=%b exp=%b", k, in_ready, (k == 3)); end
      step();
    end
    // 0x08 was taken into bank 0; complete that block with 0x09..0x0B.
    for (int j = 0; j < 20; j++) begin
      in_valid = (j < 3);
      in_data  = DW'(9 + j);
      #1;
      if (j == 0) begin
        checks++;
        if (blocks_ready !== 2'd1) begin failures++; $display("FAIL bp_blocks_ready_after_free got=%0d exp=1", blocks_ready); end
      end
      if (out_valid && out_ready) got.push_back(out_data);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 8) begin failures++; $display("FAIL bp_tail_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      exp_d = DW'(4 + i);
      checks++;
      if (got[i] !== exp_d) begin failures++; $display("FAIL bp_tail_data i=%0d got=%h exp=%h", i, got[i], exp_d); end
    end
  endtask

  task automatic test_start_block();
    logic [DW-1:0] got[$];
    logic          got_last[$];
    logic [DW-1:0] exp_d;
    int            done_cnt;
    do_reset();
    out_ready = 1'b1;
    done_cnt  = 0;
    for (int c = 0; c < 17; c++) begin
      start_block = (c == 2);
      in_valid    = (c < 7);
      case (c)
        0:       in_data = 16'h0055;
        1:       in_data = 16'h0056;
        2:       in_data = 16'h0057;
        default: in_data = DW'(32'hA0 + c - 3);
      endcase
      #1;
      if (c == 2) begin
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL sb_in_ready_during_start got=%b exp=0", in_ready); end
      end
      if (block_done) done_cnt++;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        got_last.push_back(out_last);
      end
      step();
    end
    idle_inputs();
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL sb_block_done_count got=%0d exp=1", done_cnt); end
    checks++;
    if (got.size() != 4) begin failures++; $display("FAIL sb_out_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      exp_d = DW'(32'hA0 + i);
      checks++;
      if (got[i] !== exp_d || got_last[i] !== (i == 3)) begin
        failures++; $display("FAIL sb_out_word i=%0d got d=%h l=%b exp d=%h l=%b", i, got[i], got_last[i], exp_d, (i == 3));
      end
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] exp_tab [7];
    logic          pat     [7];
    bit            seen;
    exp_tab = '{16'h0020, 16'h0021, 16'h0021, 16'h0021, 16'h0022, 16'h0022, 16'h0023};
    pat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = DW'(32'h20 + c);
      step();
    end
    idle_inputs();
    seen = 1'b0;
    for (int w = 0; w < 10; w++) begin
      #1;
      if (out_valid) begin seen = 1'b1; break; end
      step();
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL stall_wait_out_valid got=timeout exp=out_valid within 10 cycles"); end
    for (int p = 0; p < 7; p++) begin
      out_ready = pat[p];
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_tab[p] || out_last !== (p == 6)) begin
        failures++;
        $display("FAIL stall_word p=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                 p, out_valid, out_data, out_last, exp_tab[p], (p == 6));
      end
      step();
    end
    #1;
    checks++;
    if (out_valid !== 1'b0 || blocks_ready !== 2'd0) begin
      failures++; $display("FAIL stall_after_drain got v=%b br=%0d exp v=0 br=0", out_valid, blocks_ready);
    end
  endtask

  task automatic test_reset_midstream();
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_d;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 4);
      in_data  = DW'(32'hB0 + c);
      rst      = (c == 6);
      #1;
      if (c == 6) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h00B1) begin
          failures++; $display("FAIL rm_second_word got v=%b d=%h exp v=1 d=00b1", out_valid, out_data);
        end
      end
      step();
    end
    idle_inputs();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_last !== 1'b0 || blocks_ready !== 2'd0) begin
      failures++;
      $display("FAIL rm_after_reset got v=%b d=%h l=%b br=%0d exp 0,0000,0,0", out_valid, out_data, out_last, blocks_ready);
    end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rm_in_ready_in_reset got=%b exp=0", in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rm_in_ready_released got=%b exp=1", in_ready); end
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 4);
      in_data  = DW'(32'hC0 + c);
      #1;
      if (out_valid && out_ready) got.push_back(out_data);
      step();
    end
    idle_inputs();
    checks++;
    if (got.size() != 4) begin failures++; $display("FAIL rm_out_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      exp_d = DW'(32'hC0 + i);
      checks++;
      if (got[i] !== exp_d) begin failures++; $display("FAIL rm_out_data i=%0d got=%h exp=%h", i, got[i], exp_d); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      in_valid = (c < 8);
      in_data  = DW'(32'h10 + c);
      #1;
      checks++;
      if (block_done !== (c == 4 || c == 8)) begin failures++; $display("FAIL b2b_block_done c=%0d got=%b exp=%b", c, block_done, (c == 4 || c == 8)); end
      checks++;
      if (out_valid !== (c >= 5 && c <= 12)) begin failures++; $display("FAIL b2b_out_valid c=%0d got=%b exp=%b", c, out_valid, (c >= 5 && c <= 12)); end
      checks++;
      if (out_last !== (c == 8 || c == 12)) begin failures++; $display("FAIL b2b_out_last c=%0d got=%b exp=%b", c, out_last, (c == 8 || c == 12)); end
      if (c >= 5 && c <= 12) begin
        exp_d = DW'(32'h10 + c - 5);
        checks++;
        if (out_data !== exp_d) begin failures++; $display("FAIL b2b_out_data c=%0d got=%h exp=%h", c, out_data, exp_d); end
      end
      if (c < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, in_ready); end
      end
      if (c == 8) begin
        checks++;
        if (blocks_ready !== 2'd1) begin failures++; $display("FAIL b2b_blocks_ready_swap got=%0d exp=1", blocks_ready); end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_block();
    test_stall();
    test_reset_midstream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=bench completes");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pingpong_block_buffer.md
Name: pingpong_block_buffer

Overview:
- Double-buffered block store that sits directly downstream of the precision core's input block counting.
- Accepts a valid/ready sample stream and fills one bank of BLOCK_SIZE words while the other, completed bank is drained to the consumer.
- Signals write-side block completion and marks the last word of each drained block.

Parameters:
BLOCK_SIZE, 256, words per block (power of two, >=2)
DATA_W, 32, sample width in bits

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
start_block  in  1  restart fill of current write bank, discarding any partial data
in_valid  in  1  input sample valid
in_data  in  DATA_W  input sample
in_ready  out  1  input accepted when in_valid && in_ready
out_valid  out  1  output sample valid
out_data  out  DATA_W  output sample, registered
out_last  out  1  qualifies final word of a block
out_ready  in  1  consumer accepts when out_valid && out_ready
block_done  out  1  one-cycle pulse, cycle after a block's final write
blocks_ready  out  2  number of full banks not yet fully read (0..2)

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- State:
  - Two banks of BLOCK_SIZE x DATA_W.
  - wb (write bank), rb (read bank), wr_ptr and rd_ptr, each $clog2(BLOCK_SIZE) bits.
  - bank_full[1:0].
- Reset: all pointers, wb, rb and bank_full are 0; out_valid=0, out_data=0, out_last=0, block_done=0. in_ready=0 while rst is high. Memory contents are don't-care.
- Write side:
  - in_ready = !rst && !bank_full[wb] && !start_block (combinational from registers/inputs).
  - Accept: mem[wb][wr_ptr] <= in_data; wr_ptr increments.
  - When an accept hits wr_ptr == BLOCK_SIZE-1:
    - bank_full[wb] <= 1, wb toggles, wr_ptr <= 0.
    - block_done is 1 in the next cycle only.
  - start_block: wr_ptr <= 0; a same-cycle in_valid is not accepted; bank_full, wb and the read side are unchanged; block_done is not pulsed.
- Read side (one-deep registered output):
  - Load condition: bank_full[rb] && (!out_valid || out_ready).
  - On load: out_data <= mem[rb][rd_ptr], out_valid <= 1, out_last <= (rd_ptr == BLOCK_SIZE-1), rd_ptr increments.
  - On the load of the last word: bank_full[rb] <= 0, rb toggles, rd_ptr <= 0.
  - Else if out_ready: out_valid <= 0, out_last <= 0.
  - While out_valid && !out_ready, out_data and out_last are held stable.
- Latency:
  - Final write at cycle T: bank_full set at T+1, first word on out_valid at T+2.
  - A freed bank raises in_ready the cycle after its last word is loaded.
  - Steady state is one word per cycle on each side.
- Simultaneous events:
  - Writer completing one bank and reader freeing the other in the same cycle update independent bank_full bits; both take effect.
  - Writer and reader never touch the same bank in one cycle, because a full bank cannot be written.
- blocks_ready = bank_full[0] + bank_full[1]; in_ready is 0 whenever the count is 2.
- Reset mid-operation discards all buffered data and the output register. The first post-reset block behaves exactly as after power-up.

Test Plan:
- BLOCK_SIZE=4, DATA_W=16, out_ready=1; write 0x10..0x13 back-to-back from cycle 0 -> block_done high at cycle 4 only; out_data 0x10,0x11,0x12,0x13 at cycles 5..8, out_last only with 0x13.
- out_ready=0; stream 0x00..0x07 -> blocks_ready=2 and in_ready=0 after the 8th accept, 9th word held. Raise out_ready -> 0x00..0x03 drain; in_ready returns the cycle after 0x03 loads; 0x08 is then accepted into bank 0.
- Write 0x55,0x56, pulse start_block with in_valid=1 and in_data=0x57, then write 0xA0..0xA3 -> 0x57 not accepted; output is exactly 0xA0..0xA3, one block_done.
- Full block buffered; out_ready pattern 1,0,0,1,0,1,1 -> each word held stable while stalled; sequence order intact, no duplicates or drops.
- Assert rst while the 2nd word of a block is on the output -> next cycle out_valid=0, out_data=0, blocks_ready=0, in_ready=1 after rst drops; a new block 0xC0..0xC3 drains correctly.
- Continuous writes at one word per cycle with out_ready=1 -> bank 1 completes in the same cycle bank 0's last word loads; both bank_full updates land; output is gapless, with 0x10..0x17 in order.
